// File: rtl/dff_checker.sv
// Enable-flop checker: shadows io_Q with a model bit and counts mismatches over CHECK_CYCLES edges.
// Latency: zero; io_Q at edge k is compared with the model after edge k-1. No backpressure; io_start is ignored while busy.
// Optional DFF_CHECKER_ERR_LOG_EN records the cycle index of the first mismatch of a run.
module dff_checker #(
    parameter int CHECK_CYCLES = 16,
    parameter int ERR_W        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             io_start,
    input  logic             io_D,
    input  logic             io_EN,
    input  logic             io_Q,
    output logic             io_busy,
    output logic             io_pass,
    output logic             io_fail,
    output logic [ERR_W-1:0] io_err_count,
    output logic [15:0]      io_first_err_cycle
);

    typedef enum logic [1:0] {IDLE, CHECK, PASS, FAIL} state_t;

    localparam logic [15:0]      LAST_CYC = 16'(CHECK_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    state_t      state_q, state_d;
    logic [15:0] cyc_q;
    logic        model_q;
    logic        model_valid;
    logic        mismatch;
    logic        last_cycle;
    logic        start_run;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        start_run  = 1'b0;
        mismatch   = (state_q == CHECK) && model_valid && (io_Q != model_q);
        last_cycle = (state_q == CHECK) && (cyc_q == LAST_CYC);
        case (state_q)
            IDLE, PASS, FAIL: begin
                if (io_start) begin
                    state_d   = CHECK;
                    start_run = 1'b1;
                end
            end
            CHECK: begin
                // The final edge's own mismatch must decide the verdict too.
                if (last_cycle)
                    state_d = (io_err_count == '0 && !mismatch) ? PASS : FAIL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q        <= '0;
            model_q      <= 1'b0;
            model_valid  <= 1'b0;
            io_err_count <= '0;
        end else if (start_run) begin
            cyc_q        <= '0;
            model_valid  <= 1'b0;
            io_err_count <= '0;
        end else if (state_q == CHECK) begin
            if (mismatch && io_err_count != ERR_MAX)
                io_err_count <= io_err_count + ERR_ONE;
            if (io_EN) begin
                model_q     <= io_D;
                model_valid <= 1'b1;
            end
            if (!last_cycle)
                cyc_q <= cyc_q + 16'd1;
        end
    end

`ifdef DFF_CHECKER_ERR_LOG_EN
    logic [15:0] first_err_q;

    // A zero count means no mismatch has been recorded yet this run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            first_err_q <= '0;
        else if (start_run)
            first_err_q <= '0;
        else if (mismatch && io_err_count == '0)
            first_err_q <= cyc_q;
    end

    assign io_first_err_cycle = first_err_q;
`else
    assign io_first_err_cycle = 16'd0;
`endif

    assign io_busy = (state_q == CHECK);
    assign io_pass = (state_q == PASS);
    assign io_fail = (state_q == FAIL);

endmodule

// File: tb/tb_dff_checker.sv
// Bench for dff_checker: two instances (ERR_W=8 and ERR_W=2) share the stimulus and are checked
// every cycle against a run-level model, plus literal expectations at the end of each scenario.
module tb_dff_checker;

    localparam int CC = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_start = 1'b0;
    logic        io_D = 1'b0;
    logic        io_EN = 1'b0;
    logic        io_Q = 1'b0;
    logic        busy_a, pass_a, fail_a, busy_b, pass_b, fail_b;
    logic [7:0]  err_a;
    logic [1:0]  err_b;
    logic [15:0] first_a, first_b;

    dff_checker #(.CHECK_CYCLES(CC), .ERR_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .io_start(io_start), .io_D(io_D), .io_EN(io_EN), .io_Q(io_Q),
        .io_busy(busy_a), .io_pass(pass_a), .io_fail(fail_a),
        .io_err_count(err_a), .io_first_err_cycle(first_a)
    );

    dff_checker #(.CHECK_CYCLES(CC), .ERR_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .io_start(io_start), .io_D(io_D), .io_EN(io_EN), .io_Q(io_Q),
        .io_busy(busy_b), .io_pass(pass_b), .io_fail(fail_b),
        .io_err_count(err_b), .io_first_err_cycle(first_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Run-level model: a run is busy, then ends pass/fail; mismatches are counted against
    // the last enabled data value seen earlier in the run.
    bit m_busy, m_pass, m_fail, has_d, last_d, fq;
    int idx, mism, first_i;
    bit cmp_on = 1'b0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int exp_first();
`ifdef DFF_CHECKER_ERR_LOG_EN
        return first_i;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("busy_a", int'(busy_a), int'(m_busy));
            check("pass_a", int'(pass_a), int'(m_pass));
            check("fail_a", int'(fail_a), int'(m_fail));
            check("err_a", int'(err_a), sat(mism, 255));
            check("first_a", int'(first_a), exp_first());
            check("busy_b", int'(busy_b), int'(m_busy));
            check("pass_b", int'(pass_b), int'(m_pass));
            check("fail_b", int'(fail_b), int'(m_fail));
            check("err_b", int'(err_b), sat(mism, 3));
            check("first_b", int'(first_b), exp_first());
        end
    end

    task automatic model_clear();
        m_busy = 0; m_pass = 0; m_fail = 0; has_d = 0; last_d = 0;
        idx = 0; mism = 0; first_i = 0;
    endtask

    task automatic cyc(input bit s, input bit d, input bit en, input bit q);
        io_start = s; io_D = d; io_EN = en; io_Q = q;
        @(posedge clk);
        if (!m_busy) begin
            if (s) begin
                model_clear();
                m_busy = 1;
            end
        end else begin
            if (has_d && q != last_d) begin
                if (mism == 0) first_i = idx;
                mism++;
            end
            if (en) begin
                last_d = d;
                has_d  = 1;
            end
            if (idx == CC - 1) begin
                m_busy = 0;
                m_pass = (mism == 0);
                m_fail = (mism != 0);
            end
            idx++;
        end
        #1;
        io_start = 1'b0;
    endtask

    // Drives io_Q from an ideal enable-flop, optionally inverted for this cycle.
    task automatic flop_cyc(input bit s, input bit d, input bit en, input bit inv);
        cyc(s, d, en, fq ^ inv);
        if (en) fq = d;
    endtask

    function automatic bit rbit();
        return bit'($urandom_range(1, 0));
    endfunction

    initial begin
        model_clear();
        fq = 0;
        #3;
        check("rst_busy", int'(busy_a), 0);
        check("rst_err", int'(err_a), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cmp_on = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, rbit(), 1, rbit());
        check("idle_hold_busy", int'(busy_a), 0);

        // Correct flop: 16 enabled random cycles.
        flop_cyc(1, 0, 0, 0);
        check("s1_start_busy", int'(busy_a), 1);
        for (int k = 0; k < CC; k++) begin
            flop_cyc(0, rbit(), 1, 0);
            if (k == CC - 2) check("s1_busy_edge15", int'(busy_a), 1);
        end
        check("s1_busy_end", int'(busy_a), 0);
        check("s1_pass", int'(pass_a), 1);
        check("s1_err", int'(err_a), 0);

        // Single fault at cycle index 5.
        flop_cyc(1, 0, 0, 0);
        check("s2_pass_cleared", int'(pass_a), 0);
        for (int k = 0; k < CC; k++) flop_cyc(0, rbit(), 1, k == 5);
        check("s2_fail", int'(fail_a), 1);
        check("s2_err", int'(err_a), 1);
`ifdef DFF_CHECKER_ERR_LOG_EN
        check("s2_first", int'(first_a), 5);
`else
        check("s2_first", int'(first_a), 0);
`endif

        // Restart from FAIL, then abort with reset at cycle 8.
        flop_cyc(1, 0, 0, 0);
        check("s3_restart_err", int'(err_a), 0);
        check("s3_restart_fail", int'(fail_a), 0);
        check("s3_restart_busy", int'(busy_a), 1);
        for (int k = 0; k < 8; k++) flop_cyc(0, rbit(), 1, k == 2);
        #1 reset_n = 1'b0;
        model_clear();
        #1;
        check("s3_arst_busy", int'(busy_a), 0);
        check("s3_arst_fail", int'(fail_a), 0);
        check("s3_arst_pass", int'(pass_a), 0);
        check("s3_arst_err", int'(err_a), 0);
        check("s3_arst_first", int'(first_a), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, rbit(), 1, rbit());
        check("s3_idle_after_rst", int'(busy_a), 0);

        // io_start mid-run is ignored: run still ends after exactly 16 edges.
        flop_cyc(1, 0, 0, 0);
        for (int k = 0; k < CC; k++) begin
            flop_cyc(k == 3, rbit(), 1, 0);
            if (k == CC - 2) check("s4_busy_edge15", int'(busy_a), 1);
        end
        check("s4_pass", int'(pass_a), 1);

        // Enable-hold: Q held at 1 passes.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 1);
        for (int k = 1; k < CC; k++) cyc(0, bit'(k & 1), 0, 1);
        check("s5_hold_pass", int'(pass_a), 1);

        // Flop that follows D regardless of enable: 7 mismatches.
        begin
            bit prevd;
            cyc(1, 0, 0, 0);
            cyc(0, 1, 1, 1);
            prevd = 1;
            for (int k = 1; k < CC; k++) begin
                cyc(0, bit'(k & 1), 0, prevd);
                prevd = bit'(k & 1);
            end
        end
        check("s6_fail", int'(fail_a), 1);
        check("s6_err_a", int'(err_a), 7);
        check("s6_err_b", int'(err_b), 3);
`ifdef DFF_CHECKER_ERR_LOG_EN
        check("s6_first", int'(first_a), 3);
`endif

        // Saturation: Q inverted after the first enable.
        flop_cyc(1, 0, 0, 0);
        flop_cyc(0, 0, 1, 0);
        for (int k = 1; k < CC; k++) flop_cyc(0, rbit(), 1, 1);
        check("s7_err_a", int'(err_a), 15);
        check("s7_err_b_sat", int'(err_b), 3);
        check("s7_fail_b", int'(fail_b), 1);

        // Enable never asserted: nothing to compare, run passes.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < CC; k++) cyc(0, rbit(), 0, rbit());
        check("s8_pass", int'(pass_a), 1);
        check("s8_err", int'(err_a), 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0);
        check("s8_stable_err", int'(err_a), 0);

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
